pll_reset_sequencer: RTL



---
 rtl/pll_reset_sequencer_if.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its environment.
// The master side is the sequencer; the slave side is the PLL/system it controls.
interface pll_reset_sequencer_if #(
    parameter int MAX_RETRIES = 3
) ();
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic          locked;
    logic          soft_req;
    logic          pll_rst;
    logic          rst_out_n;
    logic          ready;
    logic          fail;
    logic          lost_lock;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    state;

    modport master (
        input  locked, soft_req,
        output pll_rst, rst_out_n, ready, fail, lost_lock, retry_cnt, state
    );

    modport slave (
        output locked, soft_req,
        input  pll_rst, rst_out_n, ready, fail, lost_lock, retry_cnt, state
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses PLL reset, waits for lock with timeout and retries,
// qualifies lock over a stable window, then releases the system reset.
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                   refclk,
    input  logic                   rst_n,
    pll_reset_sequencer_if.master  bus
);
    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CW-1:0] CNT_RST_END = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TO_END  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_STB_END = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [RW-1:0]          r_retry;
    logic                   r_lost;
    logic                   r_pll_rst;
    logic                   r_rst_out_n;
    logic                   r_ready;
    logic                   r_fail;
    logic [SYNC_STAGES-1:0] r_sync;

    state_t                 w_state_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [RW-1:0]          w_retry_nxt;
    logic                   w_lost_nxt;
    logic                   w_pll_rst_nxt;
    logic                   w_rst_out_n_nxt;
    logic                   w_ready_nxt;
    logic                   w_fail_nxt;
    logic                   w_locked_s;

    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // Lock-flag synchroniser into the refclk domain
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.locked};
        end
    end

    // Next-state, counter, retry and sticky-flag logic plus Moore output decode of next state
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_lost_nxt  = r_lost;
        if (bus.soft_req) begin
            w_state_nxt = S_RESET_PLL;
            w_retry_nxt = {RW{1'b0}};
            w_lost_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == CNT_RST_END) w_state_nxt = S_WAIT_LOCK;
                    else                      w_state_nxt = r_state;
                end
                S_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = S_STABLE;
                    end else if (r_cnt == CNT_TO_END) begin
                        if (r_retry == RETRY_MAX) begin
                            w_state_nxt = S_FAIL;
                        end else begin
                            w_state_nxt = S_RESET_PLL;
                            w_retry_nxt = r_retry + RW'(1'b1);
                        end
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_STABLE: begin
                    if (!w_locked_s)                w_state_nxt = S_WAIT_LOCK;
                    else if (r_cnt == CNT_STB_END) w_state_nxt = S_RUN;
                    else                            w_state_nxt = r_state;
                end
                S_RUN: begin
                    if (!w_locked_s) begin
                        w_state_nxt = S_RESET_PLL;
                        w_lost_nxt  = 1'b1;
                        w_retry_nxt = {RW{1'b0}};
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_FAIL:  w_state_nxt = S_FAIL;
                default: w_state_nxt = S_RESET_PLL;
            endcase
        end

        // RUN and FAIL hold the count so it can never wrap while parked
        if (bus.soft_req || (w_state_nxt != r_state)) begin
            w_cnt_nxt = {CW{1'b0}};
        end else if ((r_state == S_RUN) || (r_state == S_FAIL)) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + CW'(1'b1);
        end

        w_pll_rst_nxt   = 1'b1;
        w_rst_out_n_nxt = 1'b0;
        w_ready_nxt     = 1'b0;
        w_fail_nxt      = 1'b0;
        case (w_state_nxt)
            S_RESET_PLL: w_pll_rst_nxt = 1'b1;
            S_WAIT_LOCK: w_pll_rst_nxt = 1'b0;
            S_STABLE:    w_pll_rst_nxt = 1'b0;
            S_RUN: begin
                w_pll_rst_nxt   = 1'b0;
                w_rst_out_n_nxt = 1'b1;
                w_ready_nxt     = 1'b1;
            end
            S_FAIL: begin
                w_pll_rst_nxt = 1'b1;
                w_fail_nxt    = 1'b1;
            end
            default: w_pll_rst_nxt = 1'b1;
        endcase
    end

    // State, counter and registered-output update
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= {CW{1'b0}};
            r_retry     <= {RW{1'b0}};
            r_lost      <= 1'b0;
            r_pll_rst   <= 1'b1;
            r_rst_out_n <= 1'b0;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_lost      <= w_lost_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_rst_out_n <= w_rst_out_n_nxt;
            r_ready     <= w_ready_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.rst_out_n = r_rst_out_n;
    assign bus.ready     = r_ready;
    assign bus.fail      = r_fail;
    assign bus.lost_lock = r_lost;
    assign bus.retry_cnt = r_retry;
    assign bus.state     = r_state;
endmodule
